add_stim_driver: RTL and testbench

- Synthesizable initiator for the registered 4-bit adder interface (clk, a, b, sum).
- Launches one operand pair per cycle into the adder and captures the registered sum two edges later.
- Compares the captured sum against an internally computed expected value and reports a pass/fail summary.
- Sits at the driving end of the adder interface, replacing hand-written testbench stimulus in self-test builds.

---
 rtl/add_stim_pkg.sv | 29 ++
 rtl/add_stim_driver_if.sv | 11 +
 rtl/add_stim_lfsr.sv | 29 ++
 rtl/add_stim_driver.sv | 146 ++++++++++++++
 tb/tb_add_stim_driver.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/add_stim_pkg.sv
// Shared types and constants for the adder stimulus driver: FSM states, operand modes,
// LFSR tap masks and the full-width expected-sum helper.
package add_stim_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    typedef enum logic {
        ModeCount = 1'b0,
        ModeLfsr  = 1'b1
    } mode_e;

    // Fibonacci tap masks: bit n-1 set for tap n.
    localparam logic [7:0]  LfsrTaps8  = 8'hB8;   // taps 8,6,5,4
    localparam logic [15:0] LfsrTaps16 = 16'hD008; // taps 16,15,13,4

    function automatic logic [15:0] lfsr_taps(int unsigned width);
        return (width == 4) ? {8'h00, LfsrTaps8} : LfsrTaps16;
    endfunction

    function automatic logic [8:0] exp_sum(logic [7:0] x, logic [7:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

endpackage

// File: rtl/add_stim_driver_if.sv
// Operand/sum bus between the stimulus driver (master) and the registered adder (slave).
interface add_stim_driver_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;

    modport master (output a, output b, input sum);
    modport slave  (input a, input b, output sum);
endinterface

// File: rtl/add_stim_lfsr.sv
// Seedable Fibonacci LFSR; value shows the seed in the load cycle so a launch can use it
// at the same edge the register advances past it.
module add_stim_lfsr #(
    parameter int unsigned   LW   = 8,
    parameter logic [LW-1:0] TAPS = 8'hB8,
    parameter logic [LW-1:0] SEED = 8'hA5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          en,
    output logic [LW-1:0] value
);

    logic [LW-1:0] lfsr_q;

    always_comb value = load ? SEED : lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (en) begin
            lfsr_q <= {value[LW-2:0], ^(value & TAPS)};
        end else if (load) begin
            lfsr_q <= SEED;
        end
    end

endmodule

// File: rtl/add_stim_driver.sv
// Self-test initiator: launches NUM_TXN operand pairs into a registered adder, checks each
// sum two edges later and reports mismatch count, first failing pair and pass/done levels.
module add_stim_driver
    import add_stim_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned NUM_TXN   = 16,
    parameter logic [15:0] LFSR_SEED = 16'h00A5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               mode,
    add_stim_driver_if.master  bus,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [7:0]         err_cnt,
    output logic [WIDTH:0]     fail_exp,
    output logic [WIDTH:0]     fail_got
);

    localparam int unsigned     LW       = 2 * WIDTH;
    localparam logic [15:0]     TapsFull = lfsr_taps(WIDTH);
    localparam logic [LW-1:0]   Taps     = TapsFull[LW-1:0];
    localparam logic [LW-1:0]   Seed     = LFSR_SEED[LW-1:0];
    localparam logic [7:0]      LastIdx  = 8'(NUM_TXN - 1);

    state_e           state_q, state_d;
    mode_e            mode_q, cur_mode;
    logic [7:0]       idx_q, cur_idx;
    logic [WIDTH-1:0] a_q, b_q, op_a, op_b;
    logic             v1_q, v2_q;
    logic [WIDTH:0]   e1_q, e2_q, op_exp;
    logic [8:0]       exp_full;
    logic [7:0]       err_q, err_d;
    logic [WIDTH:0]   fexp_q, fgot_q;
    logic             busy_q, done_q, pass_q;
    logic             start_ok, launch, last_launch, mismatch, first_miss;
    logic [LW-1:0]    lfsr_cur;

    add_stim_lfsr #(
        .LW   (LW),
        .TAPS (Taps),
        .SEED (Seed)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_ok),
        .en    (launch && (cur_mode == ModeLfsr)),
        .value (lfsr_cur)
    );

    // A start edge launches pair 0 immediately, so mode and index bypass their registers.
    always_comb begin
        start_ok    = start && ((state_q == StIdle) || (state_q == StDone));
        launch      = start_ok || (state_q == StRun);
        cur_idx     = start_ok ? 8'd0 : idx_q;
        cur_mode    = start_ok ? mode_e'(mode) : mode_q;
        last_launch = launch && (cur_idx == LastIdx);
        if (cur_mode == ModeLfsr) begin
            op_a = lfsr_cur[WIDTH-1:0];
            op_b = lfsr_cur[LW-1:WIDTH];
        end else begin
            op_a = cur_idx[WIDTH-1:0];
            op_b = cur_idx[WIDTH-1:0] + WIDTH'(5);
        end
        exp_full = exp_sum(8'(op_a), 8'(op_b));
        op_exp   = exp_full[WIDTH:0];
    end

    always_comb begin
        mismatch   = v2_q && (bus.sum != e2_q);
        first_miss = mismatch && (err_q == 8'd0);
        err_d      = err_q;
        if (start_ok) begin
            err_d = 8'd0;
        end else if (mismatch && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start_ok) state_d = last_launch ? StDrain : StRun;
            StRun:          if (last_launch) state_d = StDrain;
            // Nothing launches in DRAIN, so an empty stage 1 means both stages empty next.
            StDrain:        if (!v1_q) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mode_q  <= ModeCount;
            idx_q   <= 8'd0;
            a_q     <= '0;
            b_q     <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            e1_q    <= '0;
            e2_q    <= '0;
            err_q   <= 8'd0;
            fexp_q  <= '0;
            fgot_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                mode_q <= mode_e'(mode);
                fexp_q <= '0;
                fgot_q <= '0;
            end else if (first_miss) begin
                fexp_q <= e2_q;
                fgot_q <= bus.sum;
            end
            if (launch) begin
                idx_q <= cur_idx + 8'd1;
                a_q   <= op_a;
                b_q   <= op_b;
                e1_q  <= op_exp;
            end
            v1_q   <= launch;
            v2_q   <= start_ok ? 1'b0 : v1_q;
            e2_q   <= e1_q;
            err_q  <= err_d;
            busy_q <= (state_d == StRun) || (state_d == StDrain);
            done_q <= (state_d == StDone);
            pass_q <= (state_d == StDone) && (err_d == 8'd0);
        end
    end

    assign bus.a    = a_q;
    assign bus.b    = b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_cnt  = err_q;
    assign fail_exp = fexp_q;
    assign fail_got = fgot_q;

endmodule

// File: tb/tb_add_stim_driver.sv
// Bench for add_stim_driver: selectable adder behaviour, reference trace and scoreboard
// derived from the operand rules, randomized run sequence.
module tb_add_stim_driver;

    localparam int unsigned W = 4;
    localparam int unsigned N = 16;
    localparam int          M = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         mode = 1'b0;
    logic         busy, done, pass;
    logic [7:0]   err_cnt;
    logic [W:0]   fail_exp, fail_got;
    logic [W:0]   sum_reg;
    int           adder_kind = 0;   // 0 registered, 1 stuck at 0, 2 combinational

    int n_checks = 0;
    int n_fail   = 0;
    int pa[N];
    int pb[N];
    int exp_err, exp_fe, exp_fg;

    add_stim_driver_if #(.WIDTH(W)) bus ();

    add_stim_driver #(
        .WIDTH     (W),
        .NUM_TXN   (N),
        .LFSR_SEED (16'h00A5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .bus      (bus.master),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .fail_exp (fail_exp),
        .fail_got (fail_got)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) sum_reg <= {1'b0, bus.a} + {1'b0, bus.b};

    always_comb begin
        case (adder_kind)
            1:       bus.sum = '0;
            2:       bus.sum = {1'b0, bus.a} + {1'b0, bus.b};
            default: bus.sum = sum_reg;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int lfsr_next(input int s);
        int fb;
        fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
        return ((s << 1) | fb) & 255;
    endfunction

    // Operand trace and expected scoreboard outcome for one run under a given adder.
    task automatic build_model(input int m, input int kind);
        int s, e, g, nx;
        s = 'hA5;
        for (int k = 0; k < N; k++) begin
            if (m == 0) begin
                pa[k] = k % M;
                pb[k] = (k + 5) % M;
            end else begin
                pa[k] = s % M;
                pb[k] = (s / M) % M;
                s = lfsr_next(s);
            end
        end
        exp_err = 0;
        exp_fe  = 0;
        exp_fg  = 0;
        for (int k = 0; k < N; k++) begin
            e  = pa[k] + pb[k];
            nx = (k + 1 < N) ? k + 1 : N - 1;
            g  = (kind == 0) ? e : (kind == 1) ? 0 : pa[nx] + pb[nx];
            if (g != e) begin
                if (exp_err == 0) begin
                    exp_fe = e;
                    exp_fg = g;
                end
                if (exp_err < 255) exp_err++;
            end
        end
    endtask

    task automatic do_run(input int m, input int kind, input bit poke_start);
        adder_kind = kind;
        build_model(m, kind);
        @(negedge clk);
        start = 1'b1;
        mode  = m[0];
        @(negedge clk);
        start = 1'b0;
        mode  = 1'($urandom_range(0, 1));
        check_val("err_clear", 32'(err_cnt), 0);
        check_val("fexp_clear", 32'(fail_exp), 0);
        check_val("fgot_clear", 32'(fail_got), 0);
        // Observation t sits between edges s+t and s+t+1.
        for (int t = 0; t <= N; t++) begin
            if (t < N) begin
                check_val($sformatf("a[%0d]", t), 32'(bus.a), pa[t]);
                check_val($sformatf("b[%0d]", t), 32'(bus.b), pb[t]);
            end
            if (kind == 0 && t >= 1)
                check_val($sformatf("sum[%0d]", t - 1), 32'(bus.sum), pa[t-1] + pb[t-1]);
            check_val("busy_run", 32'(busy), 1);
            check_val("done_run", 32'(done), 0);
            start = (poke_start && t == N / 2);
            @(negedge clk);
        end
        start = 1'b0;
        check_val("done_end", 32'(done), 1);
        check_val("busy_end", 32'(busy), 0);
        check_val("err_cnt", 32'(err_cnt), exp_err);
        check_val("fail_exp", 32'(fail_exp), exp_fe);
        check_val("fail_got", 32'(fail_got), exp_fg);
        check_val("pass", 32'(pass), (exp_err == 0) ? 1 : 0);
        check_val("a_hold", 32'(bus.a), pa[N-1]);
        check_val("b_hold", 32'(bus.b), pb[N-1]);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_busy"}, 32'(busy), 0);
        check_val({tag, "_done"}, 32'(done), 0);
        check_val({tag, "_pass"}, 32'(pass), 0);
        check_val({tag, "_err"}, 32'(err_cnt), 0);
        check_val({tag, "_fexp"}, 32'(fail_exp), 0);
        check_val({tag, "_fgot"}, 32'(fail_got), 0);
        check_val({tag, "_a"}, 32'(bus.a), 0);
        check_val({tag, "_b"}, 32'(bus.b), 0);
    endtask

    initial begin
        // Start held high during reset must not launch anything.
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("idle");

        do_run(0, 0, 1'b0);
        do_run(0, 1, 1'b0);
        do_run(0, 2, 1'b0);
        do_run(1, 0, 1'b0);
        do_run(1, 0, 1'b0);
        do_run(0, 1, 1'b1);
        do_run(0, 0, 1'b0);

        // Abort a run six edges in; everything must drop at once.
        adder_kind = 0;
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle("abort");
        @(negedge clk);
        rst_n = 1'b1;
        do_run(0, 0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_run(int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
